// File: rtl/button_pkg.sv
// Shared types and default timing constants for the pushbutton controller.
// Defaults assume a 100 MHz system clock.
package button_pkg;

  localparam int CLK_FREQ                = 100_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_FREQ / 50;
  localparam int DEFAULT_LONG_CYCLES     = CLK_FREQ;

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_DEB,
    PRESSED,
    LONG,
    RELEASE_DEB
  } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is chosen by the instantiating block.
module sync_2ff #(
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_press_ctrl.sv
// Debounces one pushbutton and classifies each press as short or long.
// A short press toggles control; a long press forces it low.
module button_press_ctrl
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic control
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  btn_state_t        state, state_next;
  logic [DEB_W-1:0]  deb_cnt, deb_cnt_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
  logic              was_long, was_long_next;
  logic              btn_level_next, short_next, long_next, control_next;
  logic              btn_raw;
  logic              s;

  assign btn_raw = btn_in ^ BTN_ACTIVE_LOW;

  sync_2ff #(
    .RESET_VALUE(1'b0)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (btn_raw),
    .q      (s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RELEASED;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      was_long    <= 1'b0;
      btn_level   <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      control     <= 1'b0;
    end else begin
      state       <= state_next;
      deb_cnt     <= deb_cnt_next;
      hold_cnt    <= hold_cnt_next;
      was_long    <= was_long_next;
      btn_level   <= btn_level_next;
      short_press <= short_next;
      long_press  <= long_next;
      control     <= control_next;
    end
  end

  // hold_cnt is left untouched in RELEASE_DEB so release bounce never restarts the hold.
  always_comb begin
    state_next    = state;
    deb_cnt_next  = deb_cnt;
    hold_cnt_next = hold_cnt;
    was_long_next = was_long;
    case (state)
      RELEASED: begin
        if (s) begin
          deb_cnt_next = '0;
          state_next   = PRESS_DEB;
        end
      end
      PRESS_DEB: begin
        if (!s) begin
          state_next = RELEASED;
        end else if (deb_cnt == DEB_LAST) begin
          state_next    = PRESSED;
          hold_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          deb_cnt_next  = '0;
          was_long_next = 1'b0;
          state_next    = RELEASE_DEB;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = LONG;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end
      LONG: begin
        if (!s) begin
          deb_cnt_next  = '0;
          was_long_next = 1'b1;
          state_next    = RELEASE_DEB;
        end
      end
      RELEASE_DEB: begin
        if (s) begin
          state_next = was_long ? LONG : PRESSED;
        end else if (deb_cnt == DEB_LAST) begin
          state_next = RELEASED;
        end else begin
          deb_cnt_next = deb_cnt + 1'b1;
        end
      end
      default: state_next = RELEASED;
    endcase
  end

  // Release (s=0) is tested first in PRESSED, so it beats hold expiry on the same cycle.
  always_comb begin
    btn_level_next = btn_level;
    control_next   = control;
    short_next     = 1'b0;
    long_next      = 1'b0;
    case (state)
      PRESS_DEB: begin
        if (s && deb_cnt == DEB_LAST) btn_level_next = 1'b1;
      end
      PRESSED: begin
        if (s && hold_cnt == HOLD_LAST) begin
          long_next    = 1'b1;
          control_next = 1'b0;
        end
      end
      RELEASE_DEB: begin
        if (!s && deb_cnt == DEB_LAST) begin
          btn_level_next = 1'b0;
          if (!was_long) begin
            short_next   = 1'b1;
            control_next = ~control;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_button_press_ctrl.sv
// Scoreboard bench: a run-length reference model predicts level, control and
// press events; a negedge monitor pops expected events as the DUT pulses.
module tb_button_press_ctrl;

  localparam int D = 4;
  localparam int L = 20;

  typedef struct {
    bit is_long;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, short_press, long_press, control;

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  ev_t exp_q[$];
  bit  pipe1, pipe2;
  bit  m_level, m_control, is_long;
  int  run, held;

  button_press_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .BTN_ACTIVE_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .short_press(short_press),
    .long_press (long_press),
    .control    (control)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input bit lvl, input int n);
    btn_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic applyReset(input int n);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset_btn_level", int'(btn_level), 0);
    checkOutput("reset_control", int'(control), 0);
    checkOutput("reset_short_press", int'(short_press), 0);
    checkOutput("reset_long_press", int'(long_press), 0);
    repeat (n) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Reference model: the button as the FSM sees it is btn_in two samples late.
  // A level change is accepted after D+1 consecutive opposite samples; hold time
  // counts steady pressed samples after acceptance, excluding bounce samples.
  task automatic stepModel();
    bit s;
    s = pipe2;
    pipe2 = pipe1;
    pipe1 = btn_in;
    if (!m_level) begin
      if (s) begin
        run++;
        if (run == D + 1) begin
          m_level = 1'b1;
          run = 0;
          held = 0;
          is_long = 1'b0;
        end
      end else begin
        run = 0;
      end
    end else begin
      if (!s) begin
        run++;
        if (run == D + 1) begin
          m_level = 1'b0;
          run = 0;
          if (!is_long) begin
            m_control = !m_control;
            exp_q.push_back('{1'b0, cyc});
          end
        end
      end else if (run > 0) begin
        run = 0;
      end else if (!is_long) begin
        held++;
        if (held == L) begin
          is_long = 1'b1;
          m_control = 1'b0;
          exp_q.push_back('{1'b1, cyc});
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        pipe1 = 1'b0;
        pipe2 = 1'b0;
        m_level = 1'b0;
        m_control = 1'b0;
        is_long = 1'b0;
        run = 0;
        held = 0;
        exp_q.delete();
      end else begin
        cyc++;
        stepModel();
      end
    end
  end

  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        checkOutput("btn_level", int'(btn_level), int'(m_level));
        checkOutput("control", int'(control), int'(m_control));
        if (short_press || long_press) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_pulse_long", int'(long_press), 0);
            checkOutput("unexpected_pulse_short", int'(short_press), 0);
          end else begin
            ev = exp_q.pop_front();
            checkOutput("pulse_long", int'(long_press), int'(ev.is_long));
            checkOutput("pulse_short", int'(short_press), int'(!ev.is_long));
            checkOutput("pulse_cycle", cyc, ev.cyc);
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          ev = exp_q.pop_front();
          checkOutput(ev.is_long ? "missed_long_press" : "missed_short_press", 0, 1);
        end
      end
    end
  end

  initial begin
    bit lvl;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("initial_btn_level", int'(btn_level), 0);
    checkOutput("initial_control", int'(control), 0);
    #2 reset_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b0, 5);
    // clean short press
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 15);
    // press bounce 1,0,1,0 then stable
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 12);
    // long press
    applyStimulus(1'b1, 40);
    applyStimulus(1'b0, 12);
    // two short presses
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 12);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 12);
    // release bounce around hold_cnt=15, then held into a long press
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 30);
    applyStimulus(1'b0, 12);
    // control=1 from a short press, then reset while the button is held
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 12);
    applyStimulus(1'b1, 30);
    applyReset(3);
    applyStimulus(1'b1, 15);
    applyStimulus(1'b0, 12);
    // random segments, mostly short to exercise bounce filtering
    lvl = 1'b0;
    for (int i = 0; i < 40; i++) begin
      lvl = !lvl;
      if ($urandom_range(0, 2) == 0)
        applyStimulus(lvl, int'($urandom_range(1, 5)));
      else
        applyStimulus(lvl, int'($urandom_range(1, 30)));
    end
    applyStimulus(1'b0, 20);
    checkOutput("pending_events", exp_q.size(), 0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
